fmps_write_link: RTL and testbench

FMPS_WRITE_LINK -- requirements
Module: fmps_write_link

---
 rtl/fmps_write_link.sv | 142 ++++++++++++++
 tb/tb_fmps_write_link.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmps_write_link.sv
// FMPS write link: turns a fast-acquisition strobe into a two-beat
// AXI4-Stream packet (header, status) and keeps link statistics.
module fmps_write_link #(
    parameter int         INDEX_WIDTH = 5,
    parameter logic [7:0] MAGIC       = 8'hA5
) (
    input  logic                   auClk,
    input  logic                   auReset,
    input  logic                   auFAstrobe,
    input  logic                   enable,
    input  logic                   inhibit,
    input  logic [INDEX_WIDTH-1:0] cellIndex,
    input  logic [31:0]            fmpsStatus,
    input  logic                   countersClear,
    output logic                   auFMPSlinkTVALID,
    output logic                   auFMPSlinkTLAST,
    output logic [31:0]            auFMPSlinkTDATA,
    input  logic                   auFMPSlinkTREADY,
    output logic                   busy,
    output logic [15:0]            sentCount,
    output logic [15:0]            overrunCount,
    output logic [15:0]            inhibitCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                 state;
    state_t                 nextState;

    logic [7:0]             seq;
    logic [7:0]             capSeq;
    logic [31:0]            capStatus;
    logic [INDEX_WIDTH-1:0] capIndex;
    logic [31:0]            hdrWord;

    logic                   start;
    logic                   packetDone;
    logic                   overrunHit;
    logic                   inhibitHit;

    // Header word is built from the values frozen at the strobe,
    // so nothing on the inputs can disturb a packet in flight.
    assign hdrWord = {MAGIC, capSeq, 16'(capIndex)};

    // Next-state, stream outputs and event pulses for the counters.
    always_comb begin
        nextState        = state;
        auFMPSlinkTVALID = 1'b0;
        auFMPSlinkTLAST  = 1'b0;
        auFMPSlinkTDATA  = 32'd0;
        busy             = 1'b0;
        start            = 1'b0;
        packetDone       = 1'b0;
        overrunHit       = 1'b0;
        inhibitHit       = 1'b0;
        unique case (state)
            IDLE: begin
                if (auFAstrobe && enable) begin
                    if (inhibit) begin
                        inhibitHit = 1'b1;
                    end else begin
                        start     = 1'b1;
                        nextState = HDR;
                    end
                end
            end
            HDR: begin
                auFMPSlinkTVALID = 1'b1;
                auFMPSlinkTDATA  = hdrWord;
                busy             = 1'b1;
                overrunHit       = auFAstrobe;
                if (auFMPSlinkTREADY) begin
                    nextState = DATA;
                end
            end
            DATA: begin
                auFMPSlinkTVALID = 1'b1;
                auFMPSlinkTLAST  = 1'b1;
                auFMPSlinkTDATA  = capStatus;
                busy             = 1'b1;
                overrunHit       = auFAstrobe;
                if (auFMPSlinkTREADY) begin
                    packetDone = 1'b1;
                    nextState  = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register; reset abandons any packet in flight.
    always_ff @(posedge auClk) begin
        if (auReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Capture the packet payload when a packet is launched.
    always_ff @(posedge auClk) begin
        if (auReset) begin
            capSeq    <= 8'd0;
            capStatus <= 32'd0;
            capIndex  <= '0;
        end else if (start) begin
            capSeq    <= seq;
            capStatus <= fmpsStatus;
            capIndex  <= cellIndex;
        end
    end

    // Sequence number advances once per completed packet and is
    // deliberately untouched by countersClear.
    always_ff @(posedge auClk) begin
        if (auReset) begin
            seq <= 8'd0;
        end else if (packetDone) begin
            seq <= seq + 8'd1;
        end
    end

    // Statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge auClk) begin
        if (auReset || countersClear) begin
            sentCount    <= 16'd0;
            overrunCount <= 16'd0;
            inhibitCount <= 16'd0;
        end else begin
            sentCount    <= sentCount + 16'(packetDone);
            overrunCount <= overrunCount + 16'(overrunHit);
            inhibitCount <= inhibitCount + 16'(inhibitHit);
        end
    end

endmodule

// File: tb/tb_fmps_write_link.sv
// Bench for fmps_write_link: directed scenarios plus a randomized run
// checked against a queue-of-beats reference model.
module tb_fmps_write_link;

    logic        auClk = 1'b0;
    logic        auReset = 1'b1;
    logic        auFAstrobe = 1'b0;
    logic        enable = 1'b0;
    logic        inhibit = 1'b0;
    logic [4:0]  cellIndex = 5'd0;
    logic [31:0] fmpsStatus = 32'd0;
    logic        countersClear = 1'b0;
    logic        auFMPSlinkTVALID;
    logic        auFMPSlinkTLAST;
    logic [31:0] auFMPSlinkTDATA;
    logic        auFMPSlinkTREADY = 1'b0;
    logic        busy;
    logic [15:0] sentCount;
    logic [15:0] overrunCount;
    logic [15:0] inhibitCount;

    int errors = 0;
    int checks = 0;

    // Reference model: pending beats {last, data} and statistics.
    logic [32:0] beatQ[$];
    logic [7:0]  mSeq;
    logic [15:0] mSent;
    logic [15:0] mOver;
    logic [15:0] mInh;

    fmps_write_link #(
        .INDEX_WIDTH(5),
        .MAGIC(8'hA5)
    ) dut (
        .auClk(auClk),
        .auReset(auReset),
        .auFAstrobe(auFAstrobe),
        .enable(enable),
        .inhibit(inhibit),
        .cellIndex(cellIndex),
        .fmpsStatus(fmpsStatus),
        .countersClear(countersClear),
        .auFMPSlinkTVALID(auFMPSlinkTVALID),
        .auFMPSlinkTLAST(auFMPSlinkTLAST),
        .auFMPSlinkTDATA(auFMPSlinkTDATA),
        .auFMPSlinkTREADY(auFMPSlinkTREADY),
        .busy(busy),
        .sentCount(sentCount),
        .overrunCount(overrunCount),
        .inhibitCount(inhibitCount)
    );

    always #5 auClk = ~auClk;

    // Advance the model with the current inputs, then one clock.
    // Returns at the falling edge where outputs are sampled.
    task automatic cycle();
        logic [32:0] b;
        if (auReset) begin
            beatQ.delete();
            mSeq  = 8'd0;
            mSent = 16'd0;
            mOver = 16'd0;
            mInh  = 16'd0;
        end else begin
            if (beatQ.size() != 0) begin
                if (auFAstrobe) mOver = mOver + 16'd1;
                if (auFMPSlinkTREADY) begin
                    b = beatQ.pop_front();
                    if (b[32]) begin
                        mSent = mSent + 16'd1;
                        mSeq  = mSeq + 8'd1;
                    end
                end
            end else if (auFAstrobe && enable) begin
                if (inhibit) begin
                    mInh = mInh + 16'd1;
                end else begin
                    beatQ.push_back({1'b0, 8'hA5, mSeq, 16'(cellIndex)});
                    beatQ.push_back({1'b1, fmpsStatus});
                end
            end
            if (countersClear) begin
                mSent = 16'd0;
                mOver = 16'd0;
                mInh  = 16'd0;
            end
        end
        @(posedge auClk);
        @(negedge auClk);
    endtask

    task automatic test_reset();
        auReset = 1'b1;
        cycle();
        cycle();
        auReset = 1'b0;
        checks++;
        if ({auFMPSlinkTVALID, auFMPSlinkTLAST, auFMPSlinkTDATA, busy}
            !== 35'd0) begin
            errors++;
            $display("FAIL reset_stream: got v=%b l=%b d=%h b=%b want zeros",
                auFMPSlinkTVALID, auFMPSlinkTLAST, auFMPSlinkTDATA, busy);
        end
        checks++;
        if ({sentCount, overrunCount, inhibitCount} !== 48'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h %h %h want 0 0 0",
                sentCount, overrunCount, inhibitCount);
        end
    endtask

    task automatic test_basic();
        enable           = 1'b1;
        inhibit          = 1'b0;
        cellIndex        = 5'd3;
        fmpsStatus       = 32'hDEADBEEF;
        auFMPSlinkTREADY = 1'b1;
        auFAstrobe       = 1'b1;
        cycle();
        auFAstrobe = 1'b0;
        checks++;
        if (auFMPSlinkTVALID !== 1'b1 || auFMPSlinkTLAST !== 1'b0 ||
            auFMPSlinkTDATA !== 32'hA5000003) begin
            errors++;
            $display("FAIL basic_hdr: got v=%b l=%b d=%h want v=1 l=0 d=a5000003",
                auFMPSlinkTVALID, auFMPSlinkTLAST, auFMPSlinkTDATA);
        end
        cycle();
        checks++;
        if (auFMPSlinkTVALID !== 1'b1 || auFMPSlinkTLAST !== 1'b1 ||
            auFMPSlinkTDATA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_data: got v=%b l=%b d=%h want v=1 l=1 d=deadbeef",
                auFMPSlinkTVALID, auFMPSlinkTLAST, auFMPSlinkTDATA);
        end
        cycle();
        checks++;
        if (auFMPSlinkTVALID !== 1'b0 || busy !== 1'b0 ||
            sentCount !== 16'd1) begin
            errors++;
            $display("FAIL basic_done: got v=%b b=%b sent=%0d want 0 0 1",
                auFMPSlinkTVALID, busy, sentCount);
        end
    endtask

    task automatic test_stall();
        cellIndex        = 5'd7;
        fmpsStatus       = 32'h12345678;
        auFMPSlinkTREADY = 1'b0;
        auFAstrobe       = 1'b1;
        cycle();
        auFAstrobe = 1'b0;
        enable     = 1'b0;
        inhibit    = 1'b1;
        cellIndex  = 5'd9;
        fmpsStatus = 32'h0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (auFMPSlinkTVALID !== 1'b1 || auFMPSlinkTLAST !== 1'b0 ||
                auFMPSlinkTDATA !== 32'hA5010007 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b l=%b d=%h b=%b want 1 0 a5010007 1",
                    i, auFMPSlinkTVALID, auFMPSlinkTLAST, auFMPSlinkTDATA, busy);
            end
            cycle();
        end
        auFMPSlinkTREADY = 1'b1;
        cycle();
        checks++;
        if (auFMPSlinkTLAST !== 1'b1 || auFMPSlinkTDATA !== 32'h12345678) begin
            errors++;
            $display("FAIL stall_data: got l=%b d=%h want 1 12345678",
                auFMPSlinkTLAST, auFMPSlinkTDATA);
        end
        cycle();
        checks++;
        if (busy !== 1'b0 || auFMPSlinkTVALID !== 1'b0 ||
            sentCount !== 16'd2) begin
            errors++;
            $display("FAIL stall_done: got b=%b v=%b sent=%0d want 0 0 2",
                busy, auFMPSlinkTVALID, sentCount);
        end
        enable  = 1'b1;
        inhibit = 1'b0;
    endtask

    task automatic test_overrun();
        countersClear = 1'b1;
        cycle();
        countersClear    = 1'b0;
        auFMPSlinkTREADY = 1'b0;
        auFAstrobe       = 1'b1;
        cycle();
        cycle();
        auFAstrobe       = 1'b0;
        auFMPSlinkTREADY = 1'b1;
        cycle();
        checks++;
        if (auFMPSlinkTLAST !== 1'b1 || auFMPSlinkTVALID !== 1'b1) begin
            errors++;
            $display("FAIL overrun_in_data: got v=%b l=%b want 1 1",
                auFMPSlinkTVALID, auFMPSlinkTLAST);
        end
        auFAstrobe = 1'b1;
        cycle();
        auFAstrobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (auFMPSlinkTVALID !== 1'b0) begin
                errors++;
                $display("FAIL overrun_no_queue[%0d]: got v=%b want 0",
                    i, auFMPSlinkTVALID);
            end
            cycle();
        end
        checks++;
        if (overrunCount !== 16'd2 || sentCount !== 16'd1) begin
            errors++;
            $display("FAIL overrun_counts: got over=%0d sent=%0d want 2 1",
                overrunCount, sentCount);
        end
    endtask

    task automatic test_inhibit();
        countersClear = 1'b1;
        cycle();
        countersClear = 1'b0;
        inhibit       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            auFAstrobe = 1'b1;
            cycle();
            auFAstrobe = 1'b0;
            checks++;
            if (auFMPSlinkTVALID !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL inhibit_quiet[%0d]: got v=%b b=%b want 0 0",
                    i, auFMPSlinkTVALID, busy);
            end
            cycle();
        end
        checks++;
        if (inhibitCount !== 16'd3 || sentCount !== 16'd0) begin
            errors++;
            $display("FAIL inhibit_count: got inh=%0d sent=%0d want 3 0",
                inhibitCount, sentCount);
        end
        inhibit = 1'b0;
        enable  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            auFAstrobe = 1'b1;
            cycle();
            auFAstrobe = 1'b0;
            checks++;
            if (auFMPSlinkTVALID !== 1'b0) begin
                errors++;
                $display("FAIL disabled_quiet[%0d]: got v=%b want 0",
                    i, auFMPSlinkTVALID);
            end
            cycle();
        end
        checks++;
        if ({sentCount, overrunCount, inhibitCount} !==
            {16'd0, 16'd0, 16'd3}) begin
            errors++;
            $display("FAIL disabled_counts: got %0d %0d %0d want 0 0 3",
                sentCount, overrunCount, inhibitCount);
        end
        enable = 1'b1;
    endtask

    task automatic test_wrap();
        logic [7:0] want;
        auReset = 1'b1;
        cycle();
        auReset          = 1'b0;
        auFMPSlinkTREADY = 1'b1;
        for (int i = 0; i < 256; i++) begin
            fmpsStatus = $urandom;
            auFAstrobe = 1'b1;
            cycle();
            auFAstrobe = 1'b0;
            want = i[7:0];
            checks++;
            if (auFMPSlinkTVALID !== 1'b1 ||
                auFMPSlinkTDATA[23:16] !== want) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: got v=%b seq=%h want 1 %h",
                    i, auFMPSlinkTVALID, auFMPSlinkTDATA[23:16], want);
            end
            cycle();
            cycle();
        end
        checks++;
        if (sentCount !== 16'd256) begin
            errors++;
            $display("FAIL wrap_sent: got %0d want 256", sentCount);
        end
        auFAstrobe = 1'b1;
        cycle();
        auFAstrobe = 1'b0;
        checks++;
        if (auFMPSlinkTDATA[23:16] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_257: got seq=%h want 00",
                auFMPSlinkTDATA[23:16]);
        end
        cycle();
        countersClear = 1'b1;
        cycle();
        countersClear = 1'b0;
        checks++;
        if (sentCount !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority: got sent=%0d b=%b want 0 0",
                sentCount, busy);
        end
    endtask

    task automatic test_reset_mid();
        auReset = 1'b1;
        cycle();
        auReset          = 1'b0;
        cellIndex        = 5'd3;
        fmpsStatus       = 32'hCAFEF00D;
        auFMPSlinkTREADY = 1'b0;
        auFAstrobe       = 1'b1;
        cycle();
        auFAstrobe       = 1'b0;
        auFMPSlinkTREADY = 1'b1;
        cycle();
        auFMPSlinkTREADY = 1'b0;
        cycle();
        checks++;
        if (auFMPSlinkTVALID !== 1'b1 || auFMPSlinkTLAST !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_in_data: got v=%b l=%b want 1 1",
                auFMPSlinkTVALID, auFMPSlinkTLAST);
        end
        auReset    = 1'b1;
        auFAstrobe = 1'b1;
        cycle();
        auReset    = 1'b0;
        auFAstrobe = 1'b0;
        checks++;
        if (auFMPSlinkTVALID !== 1'b0 || busy !== 1'b0 ||
            sentCount !== 16'd0 || overrunCount !== 16'd0) begin
            errors++;
            $display("FAIL resetmid_abandon: got v=%b b=%b sent=%0d over=%0d want 0 0 0 0",
                auFMPSlinkTVALID, busy, sentCount, overrunCount);
        end
        cycle();
        checks++;
        if (auFMPSlinkTVALID !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_strobe_ignored: got v=%b want 0",
                auFMPSlinkTVALID);
        end
        auFMPSlinkTREADY = 1'b1;
        auFAstrobe       = 1'b1;
        cycle();
        auFAstrobe = 1'b0;
        checks++;
        if (auFMPSlinkTDATA !== 32'hA5000003) begin
            errors++;
            $display("FAIL resetmid_seq0: got d=%h want a5000003",
                auFMPSlinkTDATA);
        end
        cycle();
        cycle();
    endtask

    task automatic test_random();
        logic [35:0] expStream;
        logic [35:0] gotStream;
        logic [47:0] expCnt;
        logic [47:0] gotCnt;
        for (int i = 0; i < 3000; i++) begin
            auFAstrobe       = ($urandom_range(0, 3) == 0);
            enable           = ($urandom_range(0, 7) != 0);
            inhibit          = ($urandom_range(0, 7) == 0);
            auFMPSlinkTREADY = ($urandom_range(0, 2) != 0);
            countersClear    = ($urandom_range(0, 99) == 0);
            auReset          = ($urandom_range(0, 499) == 0);
            fmpsStatus       = $urandom;
            cellIndex        = 5'($urandom);
            cycle();
            if (beatQ.size() != 0) begin
                expStream = {2'b11, beatQ[0][32], 1'b1, beatQ[0][31:0]};
            end else begin
                expStream = 36'd0;
            end
            gotStream = {auFMPSlinkTVALID, busy, auFMPSlinkTLAST,
                         auFMPSlinkTVALID, auFMPSlinkTDATA};
            checks++;
            if (gotStream !== expStream) begin
                errors++;
                $display("FAIL rand_stream[%0d]: got v=%b b=%b l=%b d=%h want %h",
                    i, auFMPSlinkTVALID, busy, auFMPSlinkTLAST,
                    auFMPSlinkTDATA, expStream);
            end
            expCnt = {mSent, mOver, mInh};
            gotCnt = {sentCount, overrunCount, inhibitCount};
            checks++;
            if (gotCnt !== expCnt) begin
                errors++;
                $display("FAIL rand_counters[%0d]: got %h want %h",
                    i, gotCnt, expCnt);
            end
        end
        auReset       = 1'b0;
        auFAstrobe    = 1'b0;
        countersClear = 1'b0;
    endtask

    initial begin
        @(negedge auClk);
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_inhibit();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
